// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared FSM states, reset vector and instruction field widths
package instr_fetch_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } if_state_t;

    localparam logic [31:0] IF_RESET_PC = 32'h0000_3000;
    localparam int          IMM_W       = 16;
    localparam int          TGT_W       = 26;

endpackage

// File: rtl/instr_fetch_npc.sv
// npc_calc: combinational next-PC selection and jr misalignment detection
module npc_calc
    import instr_fetch_pkg::*;
(
    input  logic [31:0]      pc_plus4,
    input  logic [IMM_W-1:0] imm16,
    input  logic [TGT_W-1:0] target26,
    input  logic [31:0]      rs_data,
    input  logic             nPC_sel,
    input  logic             zero,
    input  logic             J,
    input  logic             jal,
    input  logic             jr,
    output logic [31:0]      npc,
    output logic             misaligned
);

    // Priority: jr, then J/jal, then taken branch, else sequential
    always_comb begin
        npc = jr             ? {rs_data[31:2], 2'b00} :
              (J | jal)      ? {pc_plus4[31:28], target26, 2'b00} :
              (nPC_sel & zero) ? pc_plus4 + {{(32-IMM_W-2){imm16[IMM_W-1]}}, imm16, 2'b00} :
                               pc_plus4;
        misaligned = jr & (|rs_data[1:0]);
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: two-state fetch/hold unit holding PC and IR with decode slices
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IF_RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [31:0]       imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic [5:0]        OpCode,
    output logic [5:0]        func,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [IMM_W-1:0]  imm16,
    output logic [TGT_W-1:0]  target26,
    output logic [31:0]       pc,
    output logic [31:0]       pc_plus4,
    output logic              instr_valid,
    input  logic              advance,
    input  logic              nPC_sel,
    input  logic              J,
    input  logic              jal,
    input  logic              jr,
    input  logic              zero,
    input  logic [31:0]       rs_data,
    output logic              addr_err
);

    if_state_t   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic        err_q, err_d;
    logic [31:0] npc;
    logic        misaligned;

    assign OpCode    = ir_q[31:26];
    assign func      = ir_q[5:0];
    assign rs        = ir_q[25:21];
    assign rt        = ir_q[20:16];
    assign rd        = ir_q[15:11];
    assign imm16     = ir_q[15:0];
    assign target26  = ir_q[25:0];
    assign pc        = pc_q;
    assign pc_plus4  = pc_q + 32'd4;
    assign imem_addr = pc_q;
    assign addr_err  = err_q;

    npc_calc u_npc (
        .pc_plus4   (pc_plus4),
        .imm16      (imm16),
        .target26   (target26),
        .rs_data    (rs_data),
        .nPC_sel    (nPC_sel),
        .zero       (zero),
        .J          (J),
        .jal        (jal),
        .jr         (jr),
        .npc        (npc),
        .misaligned (misaligned)
    );

    // Next-state: capture on strobe in FETCH, redirect on advance in HOLD
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        err_d       = err_q;
        imem_req    = (state_q == FETCH);
        instr_valid = (state_q == HOLD);
        if (state_q == FETCH && imem_ready) begin
            ir_d    = imem_rdata;
            state_d = HOLD;
        end else if (state_q == HOLD && advance) begin
            pc_d    = npc;
            err_d   = err_q | misaligned;
            state_d = FETCH;
        end
    end

    // State registers with asynchronous reset discarding any held instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed and random stimulus checked against a behavioural fetch model
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_ready = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic [5:0]  OpCode, func;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;
    logic [25:0] target26;
    logic [31:0] pc, pc_plus4, rs_data = '0;
    logic        instr_valid, addr_err;
    logic        advance = 1'b0, nPC_sel = 1'b0, J = 1'b0, jal = 1'b0, jr = 1'b0, zero = 1'b0;

    int errors = 0;
    int checks = 0;

    logic        m_valid;
    logic [31:0] m_pc, m_ir;
    logic        m_err;

    instr_fetch dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .OpCode(OpCode), .func(func),
        .rs(rs), .rt(rt), .rd(rd), .imm16(imm16), .target26(target26), .pc(pc),
        .pc_plus4(pc_plus4), .instr_valid(instr_valid), .advance(advance),
        .nPC_sel(nPC_sel), .J(J), .jal(jal), .jr(jr), .zero(zero),
        .rs_data(rs_data), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".imem_req"},    32'(imem_req),    32'(!m_valid));
        chk({tag, ".imem_addr"},   imem_addr,        m_pc);
        chk({tag, ".instr_valid"}, 32'(instr_valid), 32'(m_valid));
        chk({tag, ".pc"},          pc,               m_pc);
        chk({tag, ".pc_plus4"},    pc_plus4,         m_pc + 32'd4);
        chk({tag, ".OpCode"},      32'(OpCode),      m_ir >> 26);
        chk({tag, ".func"},        32'(func),        m_ir % 64);
        chk({tag, ".rs"},          32'(rs),          (m_ir >> 21) % 32);
        chk({tag, ".rt"},          32'(rt),          (m_ir >> 16) % 32);
        chk({tag, ".rd"},          32'(rd),          (m_ir >> 11) % 32);
        chk({tag, ".imm16"},       32'(imm16),       m_ir % 65536);
        chk({tag, ".target26"},    32'(target26),    m_ir % (1 << 26));
        chk({tag, ".addr_err"},    32'(addr_err),    32'(m_err));
    endtask

    function automatic logic [31:0] model_npc(input logic [31:0] cur, input logic [31:0] ir,
                                             input logic ns, z, j, jl, jrr, input logic [31:0] rsd);
        logic [31:0] seq;
        int          off;
        seq = cur + 32'd4;
        off = int'($signed(ir[15:0])) * 4;
        if (jrr)           return rsd - (rsd % 4);
        else if (j || jl)  return (seq & 32'hF000_0000) | ((ir % (1 << 26)) * 4);
        else if (ns && z)  return seq + 32'(off);
        return seq;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_pc    = 32'h0000_3000;
        m_ir    = '0;
        m_err   = 1'b0;
    endtask

    task automatic cyc(input logic rdy, input logic [31:0] rdat, input logic adv,
                       input logic ns, z, j, jl, jrr, input logic [31:0] rsd, input string tag);
        imem_ready = rdy; imem_rdata = rdat; advance = adv;
        nPC_sel = ns; zero = z; J = j; jal = jl; jr = jrr; rs_data = rsd;
        @(posedge clk);
        if (!m_valid && rdy) begin
            m_ir    = rdat;
            m_valid = 1'b1;
        end else if (m_valid && adv) begin
            m_err   = m_err | (jrr && (rsd % 4 != 0));
            m_pc    = model_npc(m_pc, m_ir, ns, z, j, jl, jrr, rsd);
            m_valid = 1'b0;
        end
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("rst_async");
        imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF; advance = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("rst_drop");
        imem_ready = 1'b0;
        rst_n = 1'b1;
        check_all("rst_release");
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_reset();
        chk("first_addr", imem_addr, 32'h0000_3000);
        cyc(0, 32'h0, 0, 0, 0, 0, 0, 0, 0, "wait0");
        cyc(0, 32'h0, 0, 0, 0, 0, 0, 0, 0, "wait1");
        cyc(1, 32'h3401_0005, 0, 0, 0, 0, 0, 0, 0, "ori_fetch");
        chk("ori_valid", 32'(instr_valid), 32'd1);
        chk("ori_opcode", 32'(OpCode), 32'h0D);
        chk("ori_imm", 32'(imm16), 32'h0005);

        do_reset();
        cyc(1, 32'h1000_FFFF, 0, 0, 0, 0, 0, 0, 0, "beq_fetch");
        cyc(0, 32'h0, 1, 1, 1, 0, 0, 0, 0, "beq_taken");
        chk("beq_taken_addr", imem_addr, 32'h0000_3000);
        cyc(1, 32'h1000_FFFF, 0, 0, 0, 0, 0, 0, 0, "beq_fetch2");
        cyc(0, 32'h0, 1, 1, 0, 0, 0, 0, 0, "beq_not_taken");
        chk("beq_nt_addr", imem_addr, 32'h0000_3004);
        cyc(1, 32'h0000_0020, 0, 0, 0, 0, 0, 0, 0, "add_fetch");
        cyc(0, 32'h0, 1, 0, 0, 0, 0, 0, 0, "seq_adv");
        cyc(1, 32'h0C00_0C10, 0, 0, 0, 0, 0, 0, 0, "jal_fetch");
        chk("jal_pc_plus4", pc_plus4, 32'h0000_300C);
        cyc(0, 32'h0, 1, 1, 0, 0, 1, 0, 0, "jal_adv");
        chk("jal_addr", imem_addr, 32'h0000_3040);
        cyc(1, 32'h0800_0001, 0, 0, 0, 0, 0, 0, 0, "jr_fetch");
        cyc(0, 32'h0, 1, 0, 0, 1, 0, 1, 32'h0000_3102, "jr_adv");
        chk("jr_addr", imem_addr, 32'h0000_3100);
        chk("jr_err", 32'(addr_err), 32'd1);

        cyc(0, 32'h0, 1, 0, 0, 0, 0, 0, 0, "fetch_adv");
        cyc(1, 32'h2222_3333, 1, 0, 0, 0, 0, 0, 0, "fetch_adv_ready");
        chk("fetch_adv_pc", pc, 32'h0000_3100);
        cyc(0, 32'h0, 0, 0, 0, 0, 0, 0, 0, "hold_stable0");
        cyc(1, 32'h4444_5555, 0, 0, 0, 0, 0, 0, 0, "hold_stable1");
        chk("hold_ir", 32'(imm16), 32'h3333);

        cyc(0, 32'h0, 1, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, "to_top");
        cyc(1, 32'h0000_0000, 0, 0, 0, 0, 0, 0, 0, "top_fetch");
        cyc(0, 32'h0, 1, 0, 0, 0, 0, 0, 0, "wrap_adv");
        chk("wrap_addr", imem_addr, 32'h0000_0000);
        chk("err_sticky", 32'(addr_err), 32'd1);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] r;
            r = $urandom;
            cyc(r[0], $urandom, r[1], r[2], r[3], r[4] & r[5], r[6] & r[7],
                (r[8] & r[9] & r[10]), $urandom, "rand");
        end

        if (!m_valid) cyc(1, 32'h0, 0, 0, 0, 0, 0, 0, 0, "pre3010_fetch");
        cyc(0, 32'h0, 1, 0, 0, 0, 0, 1, 32'h0000_3010, "to_3010");
        cyc(1, 32'hABCD_1234, 0, 0, 0, 0, 0, 0, 0, "fetch_3010");
        chk("hold_pc_3010", pc, 32'h0000_3010);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("mid_hold_rst");
        chk("mid_hold_rst_valid", 32'(instr_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all("post_rst");
        chk("post_rst_addr", imem_addr, 32'h0000_3000);
        chk("post_rst_err", 32'(addr_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h0000_3000, address of the first instruction fetched after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 imem_req  output  1  fetch request to instruction memory.
REQ-005 imem_addr  output  32  word-aligned fetch address.
REQ-006 imem_ready  input  1  memory strobe; imem_rdata valid this cycle.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 OpCode, func  output  6 each  IR[31:26] and IR[5:0], wired straight to the controller decode inputs.
REQ-009 rs, rt, rd  output  5 each  IR[25:21], IR[20:16], IR[15:11].
REQ-010 imm16  output  16  IR[15:0]; target26  output  26  IR[25:0].
REQ-011 pc, pc_plus4  output  32 each  address of the held instruction and that address + 4; pc_plus4 is the jal link value.
REQ-012 instr_valid  output  1  IR holds a fetched instruction not yet retired.
REQ-013 advance  input  1  downstream retires the held instruction this cycle.
REQ-014 nPC_sel, J, jal, jr  input  1 each  controller redirect signals for the held instruction.
REQ-015 zero  input  1  ALU equality result for the held instruction.
REQ-016 rs_data  input  32  register-file rs read value (jr target).
REQ-017 addr_err  output  1  sticky flag: misaligned jr target seen.

Function
REQ-018 The FSM has exactly two states, FETCH and HOLD; reset enters FETCH.
REQ-019 In FETCH: imem_req = 1, imem_addr = PC, instr_valid = 0.
REQ-020 In FETCH with imem_ready = 1: IR <= imem_rdata; next state HOLD. Latency is one cycle from strobe to instr_valid = 1.
REQ-021 In FETCH with imem_ready = 0: state, PC and IR hold; the request stays asserted indefinitely.
REQ-022 In HOLD: imem_req = 0, instr_valid = 1; IR and PC are stable until advance.
REQ-023 advance is ignored in FETCH, including when it coincides with imem_ready.
REQ-024 In HOLD with advance = 1: PC <= next PC; next state FETCH.
REQ-025 Next-PC priority, highest first: jr -> {rs_data[31:2], 2'b00}; J or jal -> {pc_plus4[31:28], target26, 2'b00}; nPC_sel & zero -> pc_plus4 + (sign-extended imm16 << 2); otherwise pc_plus4.
REQ-026 nPC_sel = 1 with zero = 0, and no jr/J/jal, selects pc_plus4 (beq not taken).
REQ-027 All address arithmetic is 32-bit modulo 2^32; wrap-around from 32'hFFFF_FFFC to 0 is legal and not flagged.
REQ-028 jr with rs_data[1:0] != 0 sets addr_err on that advance; the PC uses the forced-aligned value; addr_err clears only on reset.
REQ-029 Decode outputs (REQ-008 to REQ-010) are combinational slices of IR; pc_plus4 is combinational from PC.
REQ-030 Redirect inputs are sampled only in the HOLD cycle where advance = 1; they are don't-care otherwise.

Reset
REQ-031 rst_n low asynchronously forces: state FETCH, PC = RESET_PC, IR = 0, addr_err = 0, instr_valid = 0.
REQ-032 After reset release, imem_req = 1 with imem_addr = RESET_PC in the first cycle.
REQ-033 Reset asserted during FETCH or HOLD discards the held instruction; a memory response arriving during reset is dropped.

Structure
REQ-034 State encodings, RESET_PC and the jump/branch field widths are defined in the shared header and included by this module.
REQ-035 One sub-module, npc_calc: purely combinational; implements REQ-025 and REQ-028 detection. PC/IR/FSM registers stay in instr_fetch.

Verification
REQ-036 Reset release, imem_ready = 1 after 2 cycles with rdata 32'h3401_0005 -> imem_addr 32'h3000; instr_valid = 1 one cycle after the strobe; OpCode 6'h0D, imm16 16'h0005.
REQ-037 HOLD at pc 32'h3000 with imm16 16'hFFFF: advance with nPC_sel = 1, zero = 1 -> next imem_addr 32'h3000; same with zero = 0 -> 32'h3004.
REQ-038 HOLD at pc 32'h3008 with target26 26'h0000C10: advance with jal = 1 and nPC_sel = 1 -> next fetch 32'h0000_3040; pc_plus4 = 32'h300C while held.
REQ-039 advance with jr = 1, J = 1 and rs_data 32'h0000_3102 -> fetch 32'h3100 (jr wins); addr_err = 1 and stays 1 until rst_n low.
REQ-040 advance pulsed during FETCH, also coincident with imem_ready -> no PC change; instruction held until a HOLD-state advance.
REQ-041 rst_n dropped mid-HOLD at pc 32'h3010 -> outputs reset immediately without a clock edge; next fetch at 32'h3000.
